// File: rtl/xge_pkt_gen_pkg.sv
// Shared types and frame layout constants for the xge_mac transmit packet generator.
package xge_pkt_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_MIN_LEN = 64;
  localparam int unsigned DEF_MAX_LEN = 9600;

  localparam int unsigned LEN_W = 14;
  localparam int unsigned IDX_W = 11;

  // Start byte of each header field; the destination address starts at byte 0.
  localparam int unsigned SRC_OFF     = 6;
  localparam int unsigned TYPE_OFF    = 12;
  localparam int unsigned SEQ_OFF     = 14;
  localparam int unsigned PAYLOAD_OFF = 16;

endpackage

// File: rtl/xge_pkt_fmt.sv
// Combinational word formatter: maps a word index within a frame to its 64-bit
// big-endian data, the eop valid-byte count and a last-word flag.
module xge_pkt_fmt
  import xge_pkt_gen_pkg::*;
#(
  parameter logic [47:0] DST_MAC   = 48'h0010_9400_0002,
  parameter logic [47:0] SRC_MAC   = 48'h0010_9400_0001,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      seq,
  output logic [63:0]      data,
  output logic [2:0]       mod,
  output logic             last
);

  int unsigned base;
  int unsigned b;

  function automatic logic [7:0] byte_at(input int unsigned bi, input logic [15:0] s);
    logic [7:0] v;
    if (bi < SRC_OFF)          v = DST_MAC[8*(SRC_OFF-1-bi) +: 8];
    else if (bi < TYPE_OFF)    v = SRC_MAC[8*(TYPE_OFF-1-bi) +: 8];
    else if (bi < SEQ_OFF)     v = ETHERTYPE[8*(SEQ_OFF-1-bi) +: 8];
    else if (bi < PAYLOAD_OFF) v = s[8*(PAYLOAD_OFF-1-bi) +: 8];
    else                       v = 8'(bi - PAYLOAD_OFF);
    return v;
  endfunction

  // NOTE: every output gets a default before the loop so no path can infer a latch.
  always_comb begin
    base = 32'(idx) * 8;
    b    = 0;
    last = (base + 8) >= 32'(len);
    mod  = last ? len[2:0] : 3'd0;
    data = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      b = base + j;
      if (b < 32'(len)) data[63-8*j -: 8] = byte_at(b, seq);
    end
  end

endmodule

// File: rtl/xge_pkt_gen.sv
// Packet source for the xge_mac TX packet interface: self-describing frames with
// sequence numbers, configurable length/count/gap, and pkt_tx_full backpressure.
module xge_pkt_gen
  import xge_pkt_gen_pkg::*;
#(
  parameter logic [47:0] DST_MAC   = 48'h0010_9400_0002,
  parameter logic [47:0] SRC_MAC   = 48'h0010_9400_0001,
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int unsigned MIN_LEN   = DEF_MIN_LEN,
  parameter int unsigned MAX_LEN   = DEF_MAX_LEN
) (
  input  logic        clk_156m25,
  input  logic        reset_156m25,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] num_pkts,
  input  logic [13:0] pkt_len,
  input  logic [7:0]  gap_cycles,
  input  logic        pkt_tx_full,
  output logic [63:0] pkt_tx_data,
  output logic        pkt_tx_val,
  output logic        pkt_tx_sop,
  output logic        pkt_tx_eop,
  output logic [2:0]  pkt_tx_mod,
  output logic        busy,
  output logic        done,
  output logic [31:0] pkt_count
);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_eff;
  logic [15:0]      num_q;
  logic [7:0]       gap_q;
  logic [7:0]       gap_cnt;
  logic [IDX_W-1:0] idx;
  logic             stop_seen;
  logic             run_end;
  logic [63:0]      fmt_data;
  logic [2:0]       fmt_mod;
  logic             fmt_last;

  always_comb begin
    len_eff = pkt_len;
    if (pkt_len < LEN_W'(MIN_LEN))      len_eff = LEN_W'(MIN_LEN);
    else if (pkt_len > LEN_W'(MAX_LEN)) len_eff = LEN_W'(MAX_LEN);
  end

  // The sequence number is the count of frames completed in this run.
  xge_pkt_fmt #(
    .DST_MAC  (DST_MAC),
    .SRC_MAC  (SRC_MAC),
    .ETHERTYPE(ETHERTYPE)
  ) u_fmt (
    .idx (idx),
    .len (len_q),
    .seq (pkt_count[15:0]),
    .data(fmt_data),
    .mod (fmt_mod),
    .last(fmt_last)
  );

  assign run_end = stop | stop_seen |
                   ((num_q != 16'd0) && (pkt_count + 32'd1 == {16'd0, num_q}));

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      state       <= ST_IDLE;
      pkt_tx_data <= '0;
      pkt_tx_val  <= 1'b0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_mod  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pkt_count   <= '0;
      len_q       <= LEN_W'(MIN_LEN);
      num_q       <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
      idx         <= '0;
      stop_seen   <= 1'b0;
    end else begin
      done       <= 1'b0;
      pkt_tx_val <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q     <= len_eff;
            num_q     <= num_pkts;
            gap_q     <= gap_cycles;
            pkt_count <= '0;
            idx       <= '0;
            stop_seen <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (stop) stop_seen <= 1'b1;
          // Under backpressure data/sop/eop hold and only val drops.
          if (!pkt_tx_full) begin
            pkt_tx_val  <= 1'b1;
            pkt_tx_data <= fmt_data;
            pkt_tx_sop  <= (idx == '0);
            pkt_tx_eop  <= fmt_last;
            pkt_tx_mod  <= fmt_mod;
            if (fmt_last) begin
              pkt_count <= pkt_count + 32'd1;
              idx       <= '0;
              if (run_end) begin
                state <= ST_DONE;
              end else if (gap_q != 8'd0) begin
                gap_cnt <= gap_q;
                state   <= ST_GAP;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (stop || stop_seen)    state   <= ST_DONE;
          else if (gap_cnt == 8'd1) state   <= ST_SEND;
          else                      gap_cnt <= gap_cnt - 8'd1;
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xge_pkt_gen.sv
// Scoreboard bench for xge_pkt_gen: frames are modelled byte by byte and queued
// at run start; an independent monitor pops and compares every valid word.
module tb_xge_pkt_gen;

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    int          gap;
  } exp_t;

  logic        clk_156m25   = 1'b0;
  logic        reset_156m25 = 1'b1;
  logic        start        = 1'b0;
  logic        stop         = 1'b0;
  logic [15:0] num_pkts     = '0;
  logic [13:0] pkt_len      = '0;
  logic [7:0]  gap_cycles   = '0;
  logic        pkt_tx_full  = 1'b0;
  logic [63:0] pkt_tx_data;
  logic        pkt_tx_val;
  logic        pkt_tx_sop;
  logic        pkt_tx_eop;
  logic [2:0]  pkt_tx_mod;
  logic        busy;
  logic        done;
  logic [31:0] pkt_count;

  exp_t sb[$];
  int   checks     = 0;
  int   failures   = 0;
  int   sop_cnt    = 0;
  int   eop_cnt    = 0;
  int   done_cnt   = 0;
  int   since_eop  = -1;
  int   frame_idle = 0;
  int   done_lat   = 1;
  int   full_mode  = 0;
  logic in_frame   = 1'b0;
  logic full_last  = 1'b0;
  logic full_force = 1'b0;

  xge_pkt_gen dut (
    .clk_156m25  (clk_156m25),
    .reset_156m25(reset_156m25),
    .start       (start),
    .stop        (stop),
    .num_pkts    (num_pkts),
    .pkt_len     (pkt_len),
    .gap_cycles  (gap_cycles),
    .pkt_tx_full (pkt_tx_full),
    .pkt_tx_data (pkt_tx_data),
    .pkt_tx_val  (pkt_tx_val),
    .pkt_tx_sop  (pkt_tx_sop),
    .pkt_tx_eop  (pkt_tx_eop),
    .pkt_tx_mod  (pkt_tx_mod),
    .busy        (busy),
    .done        (done),
    .pkt_count   (pkt_count)
  );

  always #5 clk_156m25 = ~clk_156m25;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_156m25);
    #1;
  endtask

  // Reference frame: list of bytes built from the field layout, then packed into words.
  task automatic push_frame(input int len, input int seq, input int gap);
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] etype;
    logic [15:0] s;
    logic [7:0]  fb[$];
    exp_t        e;
    int          l;
    int          nw;
    dst   = 48'h0010_9400_0002;
    src   = 48'h0010_9400_0001;
    etype = 16'h88B5;
    s     = 16'(seq);
    l     = (len < 64) ? 64 : (len > 9600) ? 9600 : len;
    for (int i = 5; i >= 0; i--) fb.push_back(dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) fb.push_back(src[8*i +: 8]);
    for (int i = 1; i >= 0; i--) fb.push_back(etype[8*i +: 8]);
    for (int i = 1; i >= 0; i--) fb.push_back(s[8*i +: 8]);
    for (int b = 16; b < l; b++) fb.push_back(8'((b - 16) % 256));
    nw = (l + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      e.data = '0;
      for (int j = 0; j < 8; j++)
        if (8*w + j < l) e.data[63-8*j -: 8] = fb[8*w + j];
      e.sop = (w == 0);
      e.eop = (w == nw - 1);
      e.mod = (w == nw - 1) ? 3'(l % 8) : 3'd0;
      e.gap = (w == 0) ? gap : -1;
      sb.push_back(e);
    end
  endtask

  task automatic recover();
    reset_156m25 = 1'b1;
    tick();
    tick();
    reset_156m25 = 1'b0;
    sb.delete();
    tick();
  endtask

  task automatic run(input int len, input int num, input int gap, input int frames,
                     input int lat, input bit stop_too);
    int d0;
    int t;
    for (int f = 0; f < frames; f++)
      push_frame(len, f, (f == 0 || full_mode != 0) ? -1 : gap);
    sop_cnt    = 0;
    eop_cnt    = 0;
    done_lat   = lat;
    d0         = done_cnt;
    pkt_len    = 14'(len);
    num_pkts   = 16'(num);
    gap_cycles = 8'(gap);
    start      = 1'b1;
    stop       = stop_too;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("busy_after_start", busy, 1);
    tick();
    if (full_mode == 0) check("first_sop_latency", {pkt_tx_val, pkt_tx_sop}, 2'b11);
    t = 0;
    while (done_cnt == d0 && t < 20000) begin
      tick();
      t++;
    end
    check("done_seen", done_cnt != d0, 1);
    if (done_cnt == d0) recover();
    tick();
    tick();
    check("single_done", done_cnt, d0 + 1);
    check("pkt_count", pkt_count, frames);
    check("busy_after_done", busy, 0);
  endtask

  task automatic wait_cnt(input bit eops, input int n);
    int t;
    t = 0;
    while ((eops ? eop_cnt : sop_cnt) < n && t < 5000) begin
      tick();
      t++;
    end
    check(eops ? "eop_reached" : "sop_reached", (eops ? eop_cnt : sop_cnt) >= n, 1);
  endtask

  // Backpressure source; stimulus changes full_force at +1, applied here at +2.
  initial begin
    forever begin
      @(posedge clk_156m25);
      #2;
      pkt_tx_full = (full_mode != 0) ? ($urandom_range(0, 3) == 0) : full_force;
    end
  end

  // Monitor: pops the scoreboard on every valid word and checks frame-level timing.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_156m25);
      if (reset_156m25) begin
        in_frame  = 1'b0;
        since_eop = -1;
        full_last = 1'b0;
        continue;
      end
      if (in_frame) check("val_vs_full", pkt_tx_val, !full_last);
      if (in_frame && !pkt_tx_val) frame_idle++;
      if (!pkt_tx_val && since_eop >= 0) since_eop++;
      if (pkt_tx_val) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=0x%0h required=none", pkt_tx_data);
        end else begin
          e = sb.pop_front();
          check("data", pkt_tx_data, e.data);
          check("sop", pkt_tx_sop, e.sop);
          check("eop", pkt_tx_eop, e.eop);
          check("mod", pkt_tx_mod, e.mod);
          if (e.sop && e.gap >= 0) check("gap_cycles", since_eop, e.gap);
        end
        if (pkt_tx_sop) begin
          in_frame   = 1'b1;
          frame_idle = 0;
          since_eop  = -1;
          sop_cnt++;
        end
        if (pkt_tx_eop) begin
          in_frame  = 1'b0;
          since_eop = 0;
          eop_cnt++;
        end
      end
      if (done) begin
        done_cnt++;
        check("sb_empty_at_done", sb.size(), 0);
        check("busy_at_done", busy, 0);
        if (done_lat >= 0) check("done_latency", since_eop, done_lat);
      end
      full_last = pkt_tx_full;
    end
  end

  initial begin
    #900000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int len;
    int num;
    repeat (3) tick();
    check("rst_val", pkt_tx_val, 0);
    check("rst_sop", pkt_tx_sop, 0);
    check("rst_eop", pkt_tx_eop, 0);
    check("rst_data", pkt_tx_data, 0);
    check("rst_mod", pkt_tx_mod, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", pkt_count, 0);
    reset_156m25 = 1'b0;
    tick();

    run(64, 1, 0, 1, 1, 1'b0);
    run(65, 1, 0, 1, 1, 1'b0);

    // Three cycles of full in mid-frame.
    fork
      run(64, 1, 0, 1, 1, 1'b0);
      begin
        tick();
        wait_cnt(1'b0, 1);
        tick();
        tick();
        full_force = 1'b1;
        repeat (3) tick();
        full_force = 1'b0;
      end
    join
    check("bp_idle_cycles", frame_idle, 3);

    // Three frames with a gap; a start pulse mid-run must be ignored.
    fork
      run(64, 3, 4, 3, 1, 1'b0);
      begin
        tick();
        wait_cnt(1'b0, 2);
        tick();
        pkt_len  = 14'd200;
        num_pkts = 16'd1;
        start    = 1'b1;
        tick();
        start = 1'b0;
      end
    join

    // Stop in idle is ignored; start with stop in the same cycle still runs fully.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    check("stop_idle_busy", busy, 0);
    run(100, 2, 1, 2, 1, 1'b1);

    // Continuous run stopped during the second frame.
    fork
      run(80, 0, 2, 2, 1, 1'b0);
      begin
        tick();
        wait_cnt(1'b0, 2);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
      end
    join

    // Continuous run stopped during the inter-frame gap.
    fork
      run(64, 0, 30, 1, -1, 1'b0);
      begin
        tick();
        wait_cnt(1'b1, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
      end
    join

    run(10, 1, 0, 1, 1, 1'b0);
    run(10000, 1, 0, 1, 1, 1'b0);

    // Reset while word 3 of a frame is on the bus.
    push_frame(64, 0, -1);
    sop_cnt    = 0;
    pkt_len    = 14'd64;
    num_pkts   = 16'd1;
    gap_cycles = 8'd0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    wait_cnt(1'b0, 1);
    tick();
    tick();
    reset_156m25 = 1'b1;
    tick();
    check("mid_rst_val", pkt_tx_val, 0);
    check("mid_rst_sop", pkt_tx_sop, 0);
    check("mid_rst_eop", pkt_tx_eop, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", pkt_count, 0);
    reset_156m25 = 1'b0;
    sb.delete();
    tick();
    run(64, 1, 0, 1, 1, 1'b0);

    // Randomised runs under random backpressure.
    full_mode = 1;
    for (int r = 0; r < 5; r++) begin
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 72)) : int'($urandom_range(64, 180));
      num = int'($urandom_range(1, 3));
      run(len, num, int'($urandom_range(0, 3)), num, 1, 1'b0);
    end
    full_mode = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
